// File: rtl/word_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : word_capture
//  Purpose  : Serial front end for file_handler. Synchronizes sclk/sdata/
//             frame_n into clk, assembles MSB-first 16-bit words, presents
//             each word with a 2-cycle load window and a byte address that
//             advances by 2 per word. Stops after WORD_LIMIT words.
//  Revision : 1.0  initial release
// ============================================================================
module word_capture #(
  parameter logic [15:0] BASE_START = 16'h0000,
  parameter int unsigned WORD_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic        sclk,
  input  logic        sdata,
  input  logic        frame_n,
  output logic [15:0] captured_data,
  output logic [15:0] ramBase,
  output logic        load,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] word_count
);

  localparam logic [15:0] c_word_limit = 16'(WORD_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_SHIFT = 3'd2,
    S_EMIT1 = 3'd3,
    S_EMIT2 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // synchronizer stages
  logic sclk_meta_q, sclk_s_q, sclk_d_q;
  logic sdata_meta_q, sdata_s_q;
  logic frame_meta_q, frame_s_q;

  // datapath / control registers
  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] captured_q, captured_d;
  logic [15:0] ram_base_q, ram_base_d;
  logic [15:0] word_count_q, word_count_d;
  logic        overrun_q, overrun_d;
  logic        load_q, load_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sclk_rise;
  logic        bit_valid;
  logic [15:0] shreg_next;
  logic [15:0] word_count_inc;

  assign sclk_rise      = sclk_s_q & ~sclk_d_q;
  assign bit_valid      = sclk_rise & ~frame_s_q;
  assign shreg_next     = {shreg_q[14:0], sdata_s_q};
  assign word_count_inc = word_count_q + 16'd1;

  // Two-flop synchronizers plus the edge-detect register on sclk.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sclk_meta_q  <= 1'b0;
      sclk_s_q     <= 1'b0;
      sclk_d_q     <= 1'b0;
      sdata_meta_q <= 1'b0;
      sdata_s_q    <= 1'b0;
      frame_meta_q <= 1'b1;
      frame_s_q    <= 1'b1;
    end else begin
      sclk_meta_q  <= sclk;
      sclk_s_q     <= sclk_meta_q;
      sclk_d_q     <= sclk_s_q;
      sdata_meta_q <= sdata;
      sdata_s_q    <= sdata_meta_q;
      frame_meta_q <= frame_n;
      frame_s_q    <= frame_meta_q;
    end
  end

  // Next-state, shifter and emission bookkeeping.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    captured_d   = captured_q;
    ram_base_d   = ram_base_q;
    word_count_d = word_count_q;
    overrun_d    = overrun_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_ARMED;
          ram_base_d   = BASE_START;
          word_count_d = 16'd0;
          overrun_d    = 1'b0;
          bit_cnt_d    = 4'd0;
        end
      end

      S_ARMED: begin
        if (!frame_s_q) begin
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // Frame loss wins over a coincident rise: the bit is not counted.
        if (frame_s_q) begin
          if (bit_cnt_q != 4'd0) begin
            bit_cnt_d = 4'd0;
            state_d   = S_ARMED;
          end
        end else if (sclk_rise) begin
          shreg_d = shreg_next;
          if (bit_cnt_q == 4'd15) begin
            captured_d = shreg_next;
            bit_cnt_d  = 4'd0;
            state_d    = S_EMIT1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_EMIT1, S_EMIT2: begin
        // Keep shifting the next word; a word completing now is dropped.
        if (bit_valid) begin
          shreg_d = shreg_next;
          if (bit_cnt_q == 4'd15) begin
            overrun_d = 1'b1;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        if (state_q == S_EMIT1) begin
          state_d = S_EMIT2;
        end else begin
          ram_base_d   = ram_base_q + 16'd2;
          word_count_d = word_count_inc;
          if (word_count_inc == c_word_limit) begin
            state_d = S_DONE;
          end else if (frame_s_q) begin
            bit_cnt_d = 4'd0;
            state_d   = S_ARMED;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    load_d = (state_d == S_EMIT1) || (state_d == S_EMIT2);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; async reset forces load low immediately.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      shreg_q      <= 16'd0;
      bit_cnt_q    <= 4'd0;
      captured_q   <= 16'd0;
      ram_base_q   <= BASE_START;
      word_count_q <= 16'd0;
      overrun_q    <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      captured_q   <= captured_d;
      ram_base_q   <= ram_base_d;
      word_count_q <= word_count_d;
      overrun_q    <= overrun_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign captured_data = captured_q;
  assign ramBase       = ram_base_q;
  assign load          = load_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overrun       = overrun_q;
  assign word_count    = word_count_q;

endmodule
`default_nettype wire
